uart_receiver: RTL

Serial-to-parallel UART receive stage. It consumes frames produced by the team's UART transmitter:
- 1 start bit (0)
- 8 payload bits sent MSB first: odd-parity bit, then data[6] down to data[0]
- 1 stop bit (1)

The block oversamples the line on a rate tick, recovers the 7-bit character, checks parity and framing, and presents the result with a one-cycle valid strobe to the consumer logic.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_receiver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding (matches the transmitter), frame widths, parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int FRAME_DATA_BITS    = 7;
  localparam int FRAME_PAYLOAD_BITS = 8;

  // Parity bit value that makes the 8-bit payload hold an odd number of ones.
  function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; presets to 1 (idle line) on reset.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ff <= '1;
    else         ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/stop recovery with parity and framing checks.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       rx,
  input  logic       sample_en,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(FRAME_PAYLOAD_BITS - 1);

  logic rs;

  state_t                        state, state_n;
  logic [TW-1:0]                 tick_cnt, tick_n;
  logic [2:0]                    bit_cnt, bit_n;
  logic [FRAME_PAYLOAD_BITS-1:0] sh, sh_n;
  logic                          armed, armed_n;
  logic [FRAME_DATA_BITS-1:0]    data_n;
  logic                          pe_n, fe_n, valid_n;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (rx),
    .q      (rs)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      sh         <= sh_n;
      armed      <= armed_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    armed_n = armed;
    data_n  = data_out;
    pe_n    = parity_err;
    fe_n    = frame_err;
    valid_n = 1'b0;

    if (sample_en) begin
      case (state)
        IDLE: begin
          // After a break the line must be seen idle before a new start counts.
          if (rs) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            if (!rs) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
            sh_n   = {sh[6:0], rs};
            bit_n  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            state_n = IDLE;
            data_n  = sh[6:0];
            pe_n    = sh[7] ^ odd_parity(sh[6:0]);
            fe_n    = ~rs;
            valid_n = 1'b1;
            armed_n = rs;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
